poly_auth_ctrl: RTL and testbench

Sequencer wrapped around the `polynomial` MAC core in the authentication datapath. It owns the core's 186-bit key register and forwards one framed byte message into the core. After a fixed drain gap it pulses the core's `start`, collects the 192-bit tag, and compares it with a reference tag. Each message produces one result record: tag, pass/fail, timeout flag and byte count.

---
 rtl/poly_auth_ctrl.sv | 167 ++++++++++++++++
 tb/tb_poly_auth_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_auth_ctrl.sv
// poly_auth_ctrl
// Sequencer around the polynomial MAC core. It holds the 186-bit key for the
// core and forwards one framed byte message to the core's stream input. After
// a fixed drain gap it pulses core_start, then collects the 192-bit tag and
// compares it with tag_ref. Each message yields one result record.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   key_in/key_valid/key_ready     key load handshake (accepted in IDLE only)
//   s_tdata/s_tvalid/s_tlast/s_tready      message byte stream in
//   core_tdata/core_tvalid/core_tready     byte stream to the core
//   core_start                     one-cycle start pulse to the core
//   core_key                       registered key to the core
//   core_tag/core_tag_valid/core_tag_ready tag from the core
//   tag_ref                        expected tag, sampled on the capture cycle
//   res_valid/res_ready            result handshake
//   res_tag/res_pass/res_timeout/res_len   result fields
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accept key loads; leave once a key exists and a byte is offered
// STREAM   | bytes pass straight through to the core, counted into len
// GAP      | drain gap of GAP_CYCLES cycles after the last byte
// START    | core_start high for one cycle, arm the timeout counter
// WAIT_TAG | accept the tag or give up when the timeout counter expires
// REPORT   | result record held stable until res_ready

module poly_auth_ctrl #(
   parameter int GAP_CYCLES     = 10,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int LEN_W          = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [185:0]       key_in,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic [7:0]         s_tdata,
   input  logic               s_tvalid,
   input  logic               s_tlast,
   output logic               s_tready,
   output logic [7:0]         core_tdata,
   output logic               core_tvalid,
   input  logic               core_tready,
   output logic               core_start,
   output logic [185:0]       core_key,
   input  logic [191:0]       core_tag,
   input  logic               core_tag_valid,
   output logic               core_tag_ready,
   input  logic [191:0]       tag_ref,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [191:0]       res_tag,
   output logic               res_pass,
   output logic               res_timeout,
   output logic [LEN_W-1:0]   res_len
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_GAP,
      S_START,
      S_WAIT_TAG,
      S_REPORT
   } state_t;

   state_t             state;
   logic               key_loaded;
   logic [LEN_W-1:0]   len;
   logic [GAP_W-1:0]   gap_cnt;
   logic [TO_W-1:0]    to_cnt;

   logic               byte_hs;

   assign byte_hs = (state == S_STREAM) && s_tvalid && core_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         key_loaded  <= 1'b0;
         core_key    <= '0;
         len         <= '0;
         gap_cnt     <= '0;
         to_cnt      <= '0;
         res_tag     <= '0;
         res_pass    <= 1'b0;
         res_timeout <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (key_valid) begin
                  core_key   <= key_in;
                  key_loaded <= 1'b1;
               end
               // The transition cycle itself does not accept a byte, so a key
               // loaded in this same cycle is already on core_key for byte one.
               if ((key_loaded || key_valid) && s_tvalid) begin
                  state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (byte_hs) begin
                  if (len != LEN_MAX) begin
                     len <= len + 1'b1;
                  end
                  if (s_tlast) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_START;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            S_START: begin
               to_cnt <= TO_LOAD;
               state  <= S_WAIT_TAG;
            end
            S_WAIT_TAG: begin
               // A tag arriving in the final window cycle still wins over timeout.
               if (core_tag_valid) begin
                  res_tag     <= core_tag;
                  res_pass    <= (core_tag == tag_ref);
                  res_timeout <= 1'b0;
                  state       <= S_REPORT;
               end else if (to_cnt == '0) begin
                  res_tag     <= '0;
                  res_pass    <= 1'b0;
                  res_timeout <= 1'b1;
                  state       <= S_REPORT;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            S_REPORT: begin
               if (res_ready) begin
                  len   <= '0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // key_ready is gated by rst so every output reads 0 while reset is held.
   assign key_ready      = !rst && (state == S_IDLE);
   assign s_tready       = (state == S_STREAM) && core_tready;
   assign core_tvalid    = (state == S_STREAM) && s_tvalid;
   assign core_tdata     = (state == S_STREAM) ? s_tdata : 8'h00;
   assign core_start     = (state == S_START);
   assign core_tag_ready = (state == S_WAIT_TAG);
   assign res_valid      = (state == S_REPORT);
   assign res_len        = len;

endmodule

// File: tb/tb_poly_auth_ctrl.sv
module tb_poly_auth_ctrl;

   localparam int GAP = 10;
   localparam int TMO = 64;
   localparam int LW  = 32;

   localparam logic [185:0] K_A = {93{2'b10}};
   localparam logic [185:0] K_B = {93{2'b01}};
   localparam logic [185:0] K_C = {62{3'b110}};
   localparam logic [191:0] TAG_A = {6{32'hDEADBEEF}};
   localparam logic [191:0] TAG_B = {6{32'h0F1E2D3C}};
   localparam logic [191:0] TAG_C = {12{16'hA5C3}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [185:0]  key_in = '0;
   logic          key_valid = 1'b0;
   logic          key_ready;
   logic [7:0]    s_tdata = 8'h00;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [7:0]    core_tdata;
   logic          core_tvalid;
   logic          core_tready = 1'b1;
   logic          core_start;
   logic [185:0]  core_key;
   logic [191:0]  core_tag = '0;
   logic          core_tag_valid = 1'b0;
   logic          core_tag_ready;
   logic [191:0]  tag_ref = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [191:0]  res_tag;
   logic          res_pass;
   logic          res_timeout;
   logic [LW-1:0] res_len;

   int checks = 0;
   int failures = 0;

   poly_auth_ctrl #(
      .GAP_CYCLES(GAP),
      .TIMEOUT_CYCLES(TMO),
      .LEN_W(LW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_in(key_in),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .s_tdata(s_tdata),
      .s_tvalid(s_tvalid),
      .s_tlast(s_tlast),
      .s_tready(s_tready),
      .core_tdata(core_tdata),
      .core_tvalid(core_tvalid),
      .core_tready(core_tready),
      .core_start(core_start),
      .core_key(core_key),
      .core_tag(core_tag),
      .core_tag_valid(core_tag_valid),
      .core_tag_ready(core_tag_ready),
      .tag_ref(tag_ref),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_tag(res_tag),
      .res_pass(res_pass),
      .res_timeout(res_timeout),
      .res_len(res_len)
   );

   always #5 clk = ~clk;

   // core-side model: ready pattern, byte capture, start pulse bookkeeping
   int         cyc = 0;
   int         start_cnt = 0;
   int         start_cyc = 0;
   int         last_cyc = 0;
   int         got_n = 0;
   logic [7:0] got [0:16383];
   bit         toggle_mode = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      core_tready <= toggle_mode ? ~core_tready : 1'b1;
      if (core_start) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
      if (core_tvalid && core_tready) begin
         got[got_n[13:0]] <= core_tdata;
         got_n <= got_n + 1;
         if (s_tlast) last_cyc <= cyc;
      end
   end

   function automatic logic [7:0] pat(input int seed, input int i);
      return 8'(i * 37 + seed);
   endfunction

   task automatic drive_msg(input int n, input int seed, input bit gaps, output bit to);
      int i;
      int guard;
      bit v;
      i = 0;
      guard = 0;
      while (i < n && guard < 80000) begin
         @(negedge clk);
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         s_tvalid = v;
         s_tdata  = pat(seed, i);
         s_tlast  = (i == n - 1);
         #1;
         if (v && s_tready) i++;
         guard++;
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      to = (i < n);
   endtask

   task automatic wait_start(output bit to);
      to = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (core_start) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({key_ready, s_tready, core_tvalid, core_tdata, core_start, core_tag_ready,
           res_valid, res_pass, res_timeout} !== '0)
         begin failures++; $display("FAIL reset_ctrl_outputs: got %b required all 0",
            {key_ready, s_tready, core_tvalid, core_tdata, core_start, core_tag_ready,
             res_valid, res_pass, res_timeout}); end
      checks++;
      if (core_key !== '0 || res_tag !== '0 || res_len !== '0)
         begin failures++; $display("FAIL reset_data_outputs: key %h tag %h len %0d required 0",
            core_key, res_tag, res_len); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b1)
         begin failures++; $display("FAIL reset_key_ready: got %b required 1", key_ready); end
   endtask

   task automatic test_key_gating();
      bit bad;
      bit to;
      int base;
      base = got_n;
      bad = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'h55;
      s_tlast  = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (s_tready !== 1'b0 || key_ready !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL gate_no_key: s_tready rose or left IDLE, got 1 required 0"); end
      key_in = K_B;
      key_valid = 1'b1;
      #1;
      checks++;
      if (key_ready !== 1'b1 || s_tready !== 1'b0)
         begin failures++; $display("FAIL gate_key_load: key_ready %b s_tready %b required 1 0", key_ready, s_tready); end
      @(negedge clk);
      checks++;
      if (core_key !== K_B)
         begin failures++; $display("FAIL gate_key_first: got %h required %h", core_key, K_B); end
      key_in  = K_A;
      s_tdata = 8'hA0;
      #1;
      checks++;
      if (key_ready !== 1'b0)
         begin failures++; $display("FAIL gate_key_ready_stream: got %b required 0", key_ready); end
      checks++;
      if (core_tvalid !== 1'b1 || s_tready !== 1'b1 || core_tdata !== 8'hA0)
         begin failures++; $display("FAIL gate_stream_start: tvalid %b tready %b data %h required 1 1 a0",
            core_tvalid, s_tready, core_tdata); end
      @(negedge clk);
      s_tdata = 8'hA1;
      s_tlast = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      key_valid = 1'b0;
      checks++;
      if (core_key !== K_B)
         begin failures++; $display("FAIL gate_key_unchanged: got %h required %h", core_key, K_B); end
      tag_ref = TAG_B;
      wait_start(to);
      core_tag = TAG_B;
      core_tag_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      core_tag_valid = 1'b0;
      checks++;
      if (to || res_valid !== 1'b1 || res_len !== 32'd2 || res_pass !== 1'b1)
         begin failures++; $display("FAIL gate_result: to %b valid %b len %0d pass %b required 0 1 2 1",
            to, res_valid, res_len, res_pass); end
      checks++;
      if (got_n - base !== 2 || got[base[13:0]] !== 8'hA0 || got[14'(base + 1)] !== 8'hA1)
         begin failures++; $display("FAIL gate_bytes: count %0d required 2 with a0 a1", got_n - base); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_basic();
      bit to1, to2;
      int base, s0, errs, idx;
      @(negedge clk);
      key_in = K_A;
      key_valid = 1'b1;
      #1;
      checks++;
      if (key_ready !== 1'b1) begin failures++; $display("FAIL basic_key_ready: got %b required 1", key_ready); end
      @(negedge clk);
      key_valid = 1'b0;
      checks++;
      if (core_key !== K_A) begin failures++; $display("FAIL basic_key: got %h required %h", core_key, K_A); end
      tag_ref = TAG_A;
      base = got_n;
      s0 = start_cnt;
      drive_msg(16, 3, 1'b0, to1);
      wait_start(to2);
      checks++;
      if (to1 || to2) begin failures++; $display("FAIL basic_progress: stream_to %b start_to %b required 0 0", to1, to2); end
      core_tag = TAG_A;
      core_tag_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (core_tag_ready !== 1'b1) begin failures++; $display("FAIL basic_tag_ready: got %b required 1", core_tag_ready); end
      @(negedge clk);
      core_tag_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_pass !== 1'b1 || res_timeout !== 1'b0 || res_len !== 32'd16)
         begin failures++; $display("FAIL basic_result: valid %b pass %b timeout %b len %0d required 1 1 0 16",
            res_valid, res_pass, res_timeout, res_len); end
      checks++;
      if (res_tag !== TAG_A) begin failures++; $display("FAIL basic_tag: got %h required %h", res_tag, TAG_A); end
      checks++;
      if (start_cyc - last_cyc !== GAP + 1)
         begin failures++; $display("FAIL basic_start_latency: got %0d required %0d", start_cyc - last_cyc, GAP + 1); end
      checks++;
      if (start_cnt - s0 !== 1) begin failures++; $display("FAIL basic_start_count: got %0d required 1", start_cnt - s0); end
      errs = 0;
      for (int k = 0; k < 16; k++) begin
         idx = base + k;
         if (got[idx[13:0]] !== pat(3, k)) errs++;
      end
      checks++;
      if (errs != 0 || got_n - base != 16)
         begin failures++; $display("FAIL basic_bytes: count %0d errors %0d required 16 0", got_n - base, errs); end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_len !== 32'd16 || res_tag !== TAG_A)
         begin failures++; $display("FAIL basic_hold: valid %b len %0d required 1 16", res_valid, res_len); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || key_ready !== 1'b1 || res_len !== '0)
         begin failures++; $display("FAIL basic_release: valid %b key_ready %b len %0d required 0 1 0",
            res_valid, key_ready, res_len); end
   endtask

   task automatic test_mismatch();
      bit to1, to2;
      tag_ref = TAG_B ^ 192'd1;
      res_ready = 1'b1;
      drive_msg(5, 11, 1'b0, to1);
      wait_start(to2);
      core_tag = TAG_B;
      core_tag_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      core_tag_valid = 1'b0;
      checks++;
      if (to1 || to2 || res_valid !== 1'b1 || res_pass !== 1'b0 || res_len !== 32'd5)
         begin failures++; $display("FAIL mismatch_result: to %b valid %b pass %b len %0d required 0 1 0 5",
            to1 | to2, res_valid, res_pass, res_len); end
      checks++;
      if (res_tag !== TAG_B) begin failures++; $display("FAIL mismatch_tag: got %h required %h", res_tag, TAG_B); end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || key_ready !== 1'b1)
         begin failures++; $display("FAIL mismatch_report_len: valid %b key_ready %b required 0 1", res_valid, key_ready); end
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit to1, to2;
      int base, errs, idx;
      base = got_n;
      tag_ref = TAG_C;
      toggle_mode = 1'b1;
      drive_msg(12500, 5, 1'b1, to1);
      toggle_mode = 1'b0;
      wait_start(to2);
      core_tag = TAG_C;
      core_tag_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      core_tag_valid = 1'b0;
      checks++;
      if (to1 || to2 || res_valid !== 1'b1 || res_len !== 32'd12500 || res_pass !== 1'b1)
         begin failures++; $display("FAIL bp_result: to %b valid %b len %0d pass %b required 0 1 12500 1",
            to1 | to2, res_valid, res_len, res_pass); end
      errs = 0;
      for (int k = 0; k < 12500; k++) begin
         idx = base + k;
         if (got[idx[13:0]] !== pat(5, k)) errs++;
      end
      checks++;
      if (errs != 0 || got_n - base != 12500)
         begin failures++; $display("FAIL bp_bytes: count %0d errors %0d required 12500 0", got_n - base, errs); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_timeout();
      bit to1, to2;
      int k;
      tag_ref = TAG_A;
      drive_msg(3, 9, 1'b0, to1);
      wait_start(to2);
      for (k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (res_valid) break;
      end
      checks++;
      if (to1 || to2 || k != TMO + 1)
         begin failures++; $display("FAIL timeout_latency: got %0d required %0d", k, TMO + 1); end
      checks++;
      if (res_timeout !== 1'b1 || res_pass !== 1'b0 || res_tag !== '0 || res_len !== 32'd3)
         begin failures++; $display("FAIL timeout_fields: timeout %b pass %b tag %h len %0d required 1 0 0 3",
            res_timeout, res_pass, res_tag, res_len); end
      core_tag = TAG_A;
      core_tag_valid = 1'b1;
      #1;
      checks++;
      if (core_tag_ready !== 1'b0) begin failures++; $display("FAIL timeout_stray_ready: got %b required 0", core_tag_ready); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      core_tag_valid = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || res_timeout !== 1'b1)
         begin failures++; $display("FAIL timeout_release: valid %b required 0", res_valid); end
   endtask

   task automatic test_reset_mid_and_min();
      bit to1, to2, bad;
      int base;
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = 8'h77;
      s_tlast  = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (core_tvalid !== 1'b1) begin failures++; $display("FAIL rst_mid_streaming: got %b required 1", core_tvalid); end
      rst = 1'b1;
      s_tvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({key_ready, s_tready, core_tvalid, core_tdata, core_start, core_tag_ready,
           res_valid, res_pass, res_timeout} !== '0 || core_key !== '0 || res_len !== '0 || res_tag !== '0)
         begin failures++; $display("FAIL rst_mid_outputs: valid %b len %0d key %h required all 0",
            res_valid, res_len, core_key); end
      @(negedge clk);
      rst = 1'b0;
      s_tvalid = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (s_tready !== 1'b0 || key_ready !== 1'b1 || res_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin failures++; $display("FAIL rst_key_cleared: block left IDLE or produced result, got 1 required 0"); end
      s_tvalid = 1'b0;
      key_in = K_C;
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      base = got_n;
      tag_ref = TAG_C;
      drive_msg(1, 20, 1'b0, to1);
      wait_start(to2);
      core_tag = TAG_C;
      core_tag_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      core_tag_valid = 1'b0;
      checks++;
      if (to1 || to2 || res_valid !== 1'b1 || res_len !== 32'd1 || res_pass !== 1'b1 || core_key !== K_C)
         begin failures++; $display("FAIL min_msg_result: valid %b len %0d pass %b required 1 1 1",
            res_valid, res_len, res_pass); end
      checks++;
      if (got_n - base != 1 || got[base[13:0]] !== pat(20, 0))
         begin failures++; $display("FAIL min_msg_byte: count %0d required 1", got_n - base); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_key_gating();
      test_basic();
      test_mismatch();
      test_backpressure();
      test_timeout();
      test_reset_mid_and_min();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
